// File: rtl/pc_call_stack.sv
// pc_call_stack: program counter with return-address stack, next-address selection and sticky stack error flags
module pc_call_stack #(
  parameter int PC_WIDTH    = 5,
  parameter int STACK_DEPTH = 8,
  parameter int SP_WIDTH    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                halt,
  input  logic                jmp,
  input  logic                cal,
  input  logic                ret,
  input  logic [PC_WIDTH-1:0] jmp_addr,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] top_addr,
  output logic [SP_WIDTH-1:0] sp,
  output logic                stack_empty,
  output logic                stack_full,
  output logic                overflow,
  output logic                underflow
);
  localparam int AW = SP_WIDTH - 1;
  logic [PC_WIDTH-1:0] stack [STACK_DEPTH];
  logic [PC_WIDTH-1:0] pc_inc;
  logic [AW-1:0]       top_idx;
  assign pc_inc      = pc + 1'b1;
  assign top_idx     = AW'(sp - 1'b1);
  assign stack_empty = sp == '0;
  assign stack_full  = sp == SP_WIDTH'(STACK_DEPTH);
  assign top_addr    = stack_empty ? '0 : stack[top_idx];
  // cal carries a companion jmp from the decoder; cal/ret are checked first so that jmp is ignored then
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc        <= '0;
      sp        <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
    end else if (!halt) begin
      if (ret) begin
        if (stack_empty) begin
          pc        <= pc_inc;
          underflow <= 1'b1;
        end else begin
          pc <= top_addr;
          sp <= sp - 1'b1;
        end
      end else if (cal) begin
        if (stack_full) begin
          pc       <= pc_inc;
          overflow <= 1'b1;
        end else begin
          stack[sp[AW-1:0]] <= pc_inc;
          sp                <= sp + 1'b1;
          pc                <= jmp_addr;
        end
      end else begin
        pc <= jmp ? jmp_addr : pc_inc;
      end
    end
endmodule

// File: doc/pc_call_stack.md
Name: pc_call_stack

Overview:
- Sequential consumer of the instruction decoder's flow-control outputs (jmp, cal, ret, jmp_addr).
- Holds the program counter and a return-address stack, and computes the next instruction address every cycle.
- Sits between the decoder and instruction memory; its pc output drives the instruction fetch address.
- Reports stack fill level and sticky overflow/underflow errors.

Parameters:
- PC_WIDTH, 5, width of program counter and of every stack entry.
- STACK_DEPTH, 8, number of return-address entries; power of two, minimum 2.
- SP_WIDTH, 4, width of stack pointer; must equal log2(STACK_DEPTH)+1 so that the value STACK_DEPTH is representable.

Ports:
- clk  in  1  system clock, rising-edge active.
- rst  in  1  reset. Asynchronous and active-high, as already decided.
- halt  in  1  when high, freezes all state.
- jmp  in  1  jump request from decoder.
- cal  in  1  call request from decoder; the decoder asserts jmp alongside it, but this block ignores that jmp.
- ret  in  1  return request from decoder.
- jmp_addr  in  PC_WIDTH  target address for jmp/cal.
- pc  out  PC_WIDTH  current instruction address, registered.
- top_addr  out  PC_WIDTH  combinational view of stack[sp-1]; 0 when empty.
- sp  out  SP_WIDTH  number of valid entries, registered.
- stack_empty  out  1  sp == 0.
- stack_full  out  1  sp == STACK_DEPTH.
- overflow  out  1  sticky: a call was attempted while full.
- underflow  out  1  sticky: a return was attempted while empty.

Behaviour:
- Reset (asynchronous assert, released synchronously by the system):
  - pc = 0, sp = 0, every stack entry = 0, overflow = 0, underflow = 0.
  - Hence stack_empty = 1, stack_full = 0, top_addr = 0.
- Timing:
  - All state updates on the rising edge of clk.
  - Control inputs are sampled at that edge.
  - The new pc is visible one cycle after the control is presented; there are no other pipeline stages.
- halt = 1: pc, sp, stack and error flags hold, and all requests are ignored. halt has priority over everything except rst.
- Priority when several requests are high in one cycle: ret > cal > jmp > sequential.
- Sequential (no request): pc <= pc + 1, modulo 2^PC_WIDTH, so 31 wraps to 0 at the default width.
- jmp only: pc <= jmp_addr; the stack is untouched.
- cal, stack not full:
  - stack[sp] <= pc + 1 (wrapped);
  - sp <= sp + 1;
  - pc <= jmp_addr.
- cal, stack full:
  - The call is dropped: no push, sp unchanged, pc <= pc + 1.
  - overflow <= 1.
- ret, stack not empty:
  - pc <= stack[sp-1];
  - sp <= sp - 1;
  - the popped entry need not be cleared.
- ret, stack empty:
  - pc <= pc + 1, sp stays 0.
  - underflow <= 1.
- Error flags are sticky; only rst clears them. The unit keeps executing after an error.
- Stack status outputs:
  - stack_full and stack_empty are pure decodes of the registered sp, so they are glitch-free relative to clk.
  - top_addr follows sp and stack contents combinationally.
- Combinational loop: jmp_addr, cal, ret and jmp may depend combinationally on pc through fetch and decode. This block samples them only at the clock edge, so no combinational path runs from those inputs to pc.
- Reset asserted mid-sequence (e.g. with nested calls pending) discards all stack contents immediately. The next fetch after release is address 0.

Test Plan:
- Reset then 33 idle cycles (no requests) -> pc counts 0,1,…,31,0,1; sp = 0; stack_empty = 1; no errors.
- At pc = 3, jmp = 1 with jmp_addr = 20 -> next pc = 20, then 21; sp stays 0.
- At pc = 4, cal = 1 with jmp_addr = 10 -> pc = 10, sp = 1, top_addr = 5. Idle two cycles (pc = 12), then ret = 1 -> pc = 5, sp = 0, stack_empty = 1.
- Nested calls:
  - Issue 8 calls, each to jmp_addr = 16 from pc = 16 -> sp = 8, stack_full = 1.
  - A 9th cal -> pc = 17, sp = 8, overflow = 1.
  - Then 8 rets -> pc returns 17 each time, sp = 0.
  - A 9th ret -> pc advances by 1, underflow = 1.
  - overflow and underflow both remain 1 until rst.
- Simultaneous cal = 1 and ret = 1 with sp = 1 and stack[0] = 7 -> ret wins: pc = 7, sp = 0, nothing pushed.
- halt = 1 for 3 cycles while cal = 1 -> pc, sp and flags unchanged. Drop halt with cal still high -> call executes on the next edge.
- rst asserted asynchronously mid-cycle with sp = 3 and overflow = 1 -> pc, sp and flags go to 0 immediately, without waiting for clk.
